// File: rtl/cp0_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg_pkg
// Description : Shared constants and helpers for the CP0 register file.
//               Holds CP0 register addresses, MEM-stage exception type codes,
//               ExcCode values, Status/Cause bit positions, reset values and
//               the exception-type decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_reg_pkg;

    // CP0 register addresses (rd field of MTC0/MFC0)
    localparam logic [4:0] c_REG_COUNT   = 5'd9;
    localparam logic [4:0] c_REG_COMPARE = 5'd11;
    localparam logic [4:0] c_REG_STATUS  = 5'd12;
    localparam logic [4:0] c_REG_CAUSE   = 5'd13;
    localparam logic [4:0] c_REG_EPC     = 5'd14;
    localparam logic [4:0] c_REG_PRID    = 5'd15;
    localparam logic [4:0] c_REG_CONFIG  = 5'd16;

    // Exception type codes presented by the MEM stage
    localparam logic [31:0] c_EXC_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] c_EXC_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] c_EXC_BREAK     = 32'h0000_0009;
    localparam logic [31:0] c_EXC_RI        = 32'h0000_000A;
    localparam logic [31:0] c_EXC_OV        = 32'h0000_000C;
    localparam logic [31:0] c_EXC_TRAP      = 32'h0000_000D;
    localparam logic [31:0] c_EXC_ERET      = 32'h0000_000E;

    // ExcCode values written into Cause[6:2]
    localparam logic [4:0] c_EXCCODE_INT  = 5'd0;
    localparam logic [4:0] c_EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] c_EXCCODE_BP   = 5'd9;
    localparam logic [4:0] c_EXCCODE_RI   = 5'd10;
    localparam logic [4:0] c_EXCCODE_OV   = 5'd12;
    localparam logic [4:0] c_EXCCODE_TRAP = 5'd13;

    // Status / Cause bit positions
    localparam int c_STATUS_EXL     = 1;
    localparam int c_CAUSE_BD       = 31;
    localparam int c_CAUSE_IV       = 23;
    localparam int c_CAUSE_WP       = 22;
    localparam int c_CAUSE_IP_HW_LO = 10;   // IP7..IP2 occupy [15:10]
    localparam int c_CAUSE_IP_SW_LO = 8;    // IP1..IP0 occupy [9:8]
    localparam int c_CAUSE_EXC_LO   = 2;    // ExcCode occupies [6:2]

    // Reset values
    localparam logic [31:0] c_STATUS_RST = 32'h1000_0000;   // CU0=1
    localparam logic [31:0] c_ZERO_RST   = 32'h0000_0000;

    // Decoded exception request
    typedef struct packed {
        logic       take;   // exception that updates EPC/Cause/EXL
        logic       eret;   // return from exception
        logic [4:0] code;   // ExcCode for a taken exception
    } exc_info_t;

    // Unknown nonzero types decode to "nothing", so they leave CP0 untouched.
    function automatic exc_info_t decode_exc(input logic [31:0] exc_type);
        exc_info_t info;
        info = '{take: 1'b0, eret: 1'b0, code: c_EXCCODE_INT};
        case (exc_type)
            c_EXC_INTERRUPT: begin info.take = 1'b1; info.code = c_EXCCODE_INT;  end
            c_EXC_SYSCALL:   begin info.take = 1'b1; info.code = c_EXCCODE_SYS;  end
            c_EXC_BREAK:     begin info.take = 1'b1; info.code = c_EXCCODE_BP;   end
            c_EXC_RI:        begin info.take = 1'b1; info.code = c_EXCCODE_RI;   end
            c_EXC_OV:        begin info.take = 1'b1; info.code = c_EXCCODE_OV;   end
            c_EXC_TRAP:      begin info.take = 1'b1; info.code = c_EXCCODE_TRAP; end
            c_EXC_ERET:      info.eret = 1'b1;
            default:         ;
        endcase
        return info;
    endfunction

endpackage : cp0_reg_pkg
`default_nettype wire

// File: rtl/cp0_reg_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg_timer
// Description : CP0 Count/Compare timer. Count free-runs, Compare sets the
//               match point, timer_int_o latches on a match and is cleared
//               only by a Compare write.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               we_i/waddr_i/wdata_i - WB-stage CP0 write port
//               count_o, compare_o - current register values
//               timer_int_o        - registered timer interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_reg_timer
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;

    // Match uses the pre-increment count; Compare==0 disables the timer.
    logic w_match;
    assign w_match = (r_compare != 32'd0) && (r_count == r_compare);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= c_ZERO_RST;
            r_compare   <= c_ZERO_RST;
            r_timer_int <= 1'b0;
        end else begin
            r_count <= r_count + 32'd1;
            if (w_match) begin
                r_timer_int <= 1'b1;
            end
            if (we_i && (waddr_i == c_REG_COUNT)) begin
                r_count <= wdata_i;
            end
            // A Compare write acknowledges the interrupt and beats a match.
            if (we_i && (waddr_i == c_REG_COMPARE)) begin
                r_compare   <= wdata_i;
                r_timer_int <= 1'b0;
            end
        end
    end

    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign timer_int_o = r_timer_int;

endmodule : cp0_reg_timer
`default_nettype wire

// File: rtl/cp0_reg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg
// Description : Coprocessor-0 register file. Accepts MTC0 writes from WB,
//               records MEM-stage exceptions (EPC/Cause/Status.EXL), samples
//               hardware interrupt lines into Cause, and serves MFC0 reads to
//               EX combinationally from register state.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               we_i/waddr_i/wdata_i     - WB-stage CP0 write port
//               raddr_i/data_o           - EX-stage read port
//               int_i                    - hardware interrupts IP7..IP2
//               excepttype_i, current_inst_addr_i, is_in_delayslot_i
//                                        - MEM-stage exception info
//               count_o..prid_o          - current register values
//               timer_int_o              - registered timer interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;

    logic [31:0] w_status_nxt;
    logic [31:0] w_cause_nxt;
    logic [31:0] w_epc_nxt;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    exc_info_t   w_exc;

    cp0_reg_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .count_o     (w_count),
        .compare_o   (w_compare),
        .timer_int_o (timer_int_o)
    );

    assign w_exc = decode_exc(excepttype_i);

    // Next-state: interrupt sampling, then the WB write, then the exception,
    // so exception fields override a same-cycle MTC0.
    always_comb begin
        w_status_nxt = r_status;
        w_cause_nxt  = r_cause;
        w_epc_nxt    = r_epc;

        w_cause_nxt[c_CAUSE_IP_HW_LO +: 6] = int_i;

        if (we_i) begin
            case (waddr_i)
                c_REG_STATUS: w_status_nxt = wdata_i;
                c_REG_CAUSE: begin
                    w_cause_nxt[c_CAUSE_IP_SW_LO +: 2] = wdata_i[c_CAUSE_IP_SW_LO +: 2];
                    w_cause_nxt[c_CAUSE_WP]            = wdata_i[c_CAUSE_WP];
                    w_cause_nxt[c_CAUSE_IV]            = wdata_i[c_CAUSE_IV];
                end
                c_REG_EPC:    w_epc_nxt = wdata_i;
                default:      ;
            endcase
        end

        if (w_exc.take) begin
            // A nested exception (EXL already set) keeps the original EPC/BD.
            if (!r_status[c_STATUS_EXL]) begin
                if (is_in_delayslot_i) begin
                    w_epc_nxt              = current_inst_addr_i - 32'd4;
                    w_cause_nxt[c_CAUSE_BD] = 1'b1;
                end else begin
                    w_epc_nxt              = current_inst_addr_i;
                    w_cause_nxt[c_CAUSE_BD] = 1'b0;
                end
            end
            w_status_nxt[c_STATUS_EXL]         = 1'b1;
            w_cause_nxt[c_CAUSE_EXC_LO +: 5]   = w_exc.code;
        end else if (w_exc.eret) begin
            w_status_nxt[c_STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= c_STATUS_RST;
            r_cause  <= c_ZERO_RST;
            r_epc    <= c_ZERO_RST;
        end else begin
            r_status <= w_status_nxt;
            r_cause  <= w_cause_nxt;
            r_epc    <= w_epc_nxt;
        end
    end

    // MFC0 read: register state only; EX forwards in-flight MTC0 values.
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            c_REG_COUNT:   data_o = w_count;
            c_REG_COMPARE: data_o = w_compare;
            c_REG_STATUS:  data_o = r_status;
            c_REG_CAUSE:   data_o = r_cause;
            c_REG_EPC:     data_o = r_epc;
            c_REG_PRID:    data_o = PRID_VAL;
            c_REG_CONFIG:  data_o = CONFIG_VAL;
            default:       data_o = 32'd0;
        endcase
    end

    assign count_o   = w_count;
    assign compare_o = w_compare;
    assign status_o  = r_status;
    assign cause_o   = r_cause;
    assign epc_o     = r_epc;
    assign prid_o    = PRID_VAL;
    assign config_o  = CONFIG_VAL;

endmodule : cp0_reg
`default_nettype wire
